enemy_scheduler: RTL and testbench
==================================

Name: enemy_scheduler

Overview:
Sequences the enemy pattern index (ene_select, 0..6) that drives the enemy pattern decoder of the hero game.
- Paces spawns from a game-tick divider.
- Picks each enemy pseudo-randomly from an LFSR.
- Shortens enemy hold time as score rises.
- Stops on collision and reports game over.

It sits between the game FSM (start/hit) and the enemy pattern decoder/display mux.

Parameters:
TICK_DIV, 25000000, clk cycles per game tick (>=2)
GAP_TICKS, 2, ticks with no enemy between spawns (>=1)
INIT_HOLD, 8, initial ticks an enemy stays on screen (>=MIN_HOLD, <=15)
MIN_HOLD, 2, floor for hold length (>=1)
SPEEDUP_EVERY, 4, dodged enemies per hold decrement (>=1)
LFSR_SEED, 8'hA5, LFSR reset value (non-zero)

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  synchronous active-low reset
start  in  1  level/pulse; starts or restarts a game
hit  in  1  collision with the current enemy
ene_select  out  3  enemy pattern index 0..6, registered
ene_valid  out  1  enemy on screen
ene_upper  out  1  1 when ene_select is 0..2 (upper segments), 0 for 3..6
score  out  8  enemies dodged, saturates at 255
level  out  4  speed-ups applied, saturates at 15
game_over  out  1  high in OVER state

Behaviour:
- Reset (rst_n=0 at an edge, any state, mid-game included):
  - Outputs: ene_select=0, ene_valid=0, ene_upper=0, score=0, level=0, game_over=0.
  - Internal: state=IDLE, lfsr=LFSR_SEED, hold_len=INIT_HOLD, tick_cnt=0, dodge_cnt=0.
- LFSR:
  - 8-bit, shifts every clk when not in reset.
  - Update: lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
  - Pick = lfsr[2:0], except 7 maps to 3.
- Tick:
  - tick_cnt counts 0..TICK_DIV-1 and wraps.
  - Internal tick is high in the cycle where tick_cnt==TICK_DIV-1.
  - tick_cnt clears to 0 on the edge that leaves IDLE or OVER.
- States:
  - IDLE: outputs idle. start=1 -> GAP, gap_cnt=GAP_TICKS.
  - GAP: ene_valid=0; hit and start ignored. Each tick decrements gap_cnt. On the tick with gap_cnt==1:
    - latch ene_select=pick and ene_upper=(pick<=2);
    - set hold_cnt=hold_len;
    - -> SHOW.
    - ene_valid=1 from the cycle after that edge.
  - SHOW: ene_valid=1; start ignored.
    - hit=1 -> OVER. ene_select is kept, ene_valid=0, game_over=1 next cycle.
    - Otherwise each tick decrements hold_cnt. On the tick with hold_cnt==1 (dodge):
      - score+1 (saturating) and dodge_cnt+1;
      - -> GAP with gap_cnt=GAP_TICKS;
      - ene_valid=0 next cycle.
    - If dodge_cnt reaches SPEEDUP_EVERY: dodge_cnt=0, and if hold_len>MIN_HOLD then hold_len-1 and level+1 (saturating). The new hold_len applies from the next spawn.
  - OVER: game_over=1, ene_valid=0, score/level frozen. start=1 -> GAP with gap_cnt=GAP_TICKS, score=0, level=0, hold_len=INIT_HOLD, dodge_cnt=0, game_over=0. The LFSR is not reseeded.
- Simultaneous events:
  - hit in the same cycle as the final SHOW tick: hit wins; no score increment.
  - start and hit together in SHOW: hit wins.
  - rst_n=0 overrides everything.
- All outputs are registered; one-cycle latency from deciding edge to output.

Test Plan:
All scenarios use TICK_DIV=4, GAP_TICKS=2, INIT_HOLD=8, MIN_HOLD=2, SPEEDUP_EVERY=4, seed 8'hA5. Start is taken at edge E0.
- Reset/idle: hold rst_n=0 for 3 edges, then release with start=0 for 50 cycles -> all outputs 0, game_over=0, ene_valid never rises.
- First spawn: pulse start at E0 -> ene_valid rises after E8 with ene_select equal to the LFSR model pick at E8 and ene_upper consistent with it. ene_valid falls after E40, then score=1.
- Speed-up: never assert hit for 4 dodges -> score=4, level=1, and the 5th enemy is valid for 7 ticks (28 cycles). After 24 dodges, level=6 and hold stays at 2 ticks thereafter.
- Collision: assert hit for 1 cycle mid-SHOW -> game_over=1 and ene_valid=0 next cycle, score frozen. Assert hit during GAP -> no effect.
- Simultaneous hit and final tick: game ends with score unchanged. Then pulse start -> score=0, level=0, game_over=0, and the next spawn comes 8 cycles later.
- Mid-game reset: drop rst_n during SHOW with score=3 -> next cycle all outputs 0, state IDLE; the LFSR restarts from 8'hA5, matching the model.

Source files
------------

// File: rtl/enemy_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : enemy_scheduler
//  Brief    : Sequences the enemy pattern index for the hero game. Spawns are
//             paced by a game-tick divider, picked from an 8-bit LFSR, held on
//             screen for a score-dependent number of ticks, and the game stops
//             on collision.
//  Revision : 1.0  initial release
// ============================================================================
module enemy_scheduler #(
  parameter int         TICK_DIV      = 25000000,
  parameter int         GAP_TICKS     = 2,
  parameter int         INIT_HOLD     = 8,
  parameter int         MIN_HOLD      = 2,
  parameter int         SPEEDUP_EVERY = 4,
  parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       hit,
  output logic [2:0] ene_select,
  output logic       ene_valid,
  output logic       ene_upper,
  output logic [7:0] score,
  output logic [3:0] level,
  output logic       game_over
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GW = $clog2(GAP_TICKS + 1);
  localparam int DW = $clog2(SPEEDUP_EVERY + 1);

  localparam logic [TW-1:0] c_tick_max  = TW'(TICK_DIV - 1);
  localparam logic [GW-1:0] c_gap       = GW'(GAP_TICKS);
  localparam logic [GW-1:0] c_gap_one   = GW'(1);
  localparam logic [3:0]    c_init_hold = 4'(INIT_HOLD);
  localparam logic [3:0]    c_min_hold  = 4'(MIN_HOLD);
  localparam logic [DW-1:0] c_speedup   = DW'(SPEEDUP_EVERY);
  localparam logic [DW-1:0] c_dodge_one = DW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GAP  = 2'd1;
  localparam logic [1:0] S_SHOW = 2'd2;
  localparam logic [1:0] S_OVER = 2'd3;

  logic [1:0]    r_state;
  logic [1:0]    w_state_next;
  logic [7:0]    r_lfsr;
  logic [TW-1:0] r_tick_cnt;
  logic [GW-1:0] r_gap_cnt;
  logic [3:0]    r_hold_cnt;
  logic [3:0]    r_hold_len;
  logic [DW-1:0] r_dodge_cnt;
  logic [2:0]    r_ene_select;
  logic          r_ene_valid;
  logic          r_ene_upper;
  logic [7:0]    r_score;
  logic [3:0]    r_level;
  logic          r_game_over;

  logic          w_tick;
  logic [2:0]    w_pick;
  logic          w_launch;
  logic          w_spawn;
  logic          w_dodge;
  logic [DW-1:0] w_dodge_inc;
  logic          w_valid_next;
  logic          w_over_next;

  assign w_tick      = (r_tick_cnt == c_tick_max);
  // Pattern 7 does not exist on the decoder, so it folds onto 3.
  assign w_pick      = (r_lfsr[2:0] == 3'd7) ? 3'd3 : r_lfsr[2:0];
  assign w_launch    = ((r_state == S_IDLE) || (r_state == S_OVER)) && start;
  assign w_spawn     = (r_state == S_GAP) && w_tick && (r_gap_cnt == c_gap_one);
  // A hit on the final tick wins over the dodge.
  assign w_dodge     = (r_state == S_SHOW) && !hit && w_tick && (r_hold_cnt == 4'd1);
  assign w_dodge_inc = r_dodge_cnt + c_dodge_one;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state decision
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_GAP;
      S_GAP:   if (w_spawn) w_state_next = S_SHOW;
      S_SHOW: begin
        if (hit)          w_state_next = S_OVER;
        else if (w_dodge) w_state_next = S_GAP;
      end
      S_OVER:  if (start) w_state_next = S_GAP;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output decode from the next state, registered below for one-cycle latency
  always_comb begin
    w_valid_next = (w_state_next == S_SHOW);
    w_over_next  = (w_state_next == S_OVER);
  end

  // Registered status flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ene_valid <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_ene_valid <= w_valid_next;
      r_game_over <= w_over_next;
    end
  end

  // Free-running LFSR; the seed is restored only by reset
  always_ff @(posedge clk) begin
    if (!rst_n) r_lfsr <= LFSR_SEED;
    else        r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  end

  // Game-tick divider, realigned whenever a game (re)starts
  always_ff @(posedge clk) begin
    if (!rst_n)                 r_tick_cnt <= '0;
    else if (w_launch || w_tick) r_tick_cnt <= '0;
    else                        r_tick_cnt <= r_tick_cnt + TW'(1);
  end

  // Gap/hold countdowns and the latched enemy pattern
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_gap_cnt    <= '0;
      r_hold_cnt   <= '0;
      r_ene_select <= 3'd0;
      r_ene_upper  <= 1'b0;
    end else begin
      if (w_launch || w_dodge)
        r_gap_cnt <= c_gap;
      else if ((r_state == S_GAP) && w_tick)
        r_gap_cnt <= r_gap_cnt - c_gap_one;

      if (w_spawn) begin
        r_hold_cnt   <= r_hold_len;
        r_ene_select <= w_pick;
        r_ene_upper  <= (w_pick <= 3'd2);
      end else if ((r_state == S_SHOW) && !hit && w_tick) begin
        r_hold_cnt <= r_hold_cnt - 4'd1;
      end
    end
  end

  // Score, difficulty level and hold length bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_score     <= 8'd0;
      r_level     <= 4'd0;
      r_hold_len  <= c_init_hold;
      r_dodge_cnt <= '0;
    end else if ((r_state == S_OVER) && start) begin
      r_score     <= 8'd0;
      r_level     <= 4'd0;
      r_hold_len  <= c_init_hold;
      r_dodge_cnt <= '0;
    end else if (w_dodge) begin
      if (r_score != 8'hFF) r_score <= r_score + 8'd1;
      if (w_dodge_inc == c_speedup) begin
        r_dodge_cnt <= '0;
        if (r_hold_len > c_min_hold) begin
          r_hold_len <= r_hold_len - 4'd1;
          if (r_level != 4'hF) r_level <= r_level + 4'd1;
        end
      end else begin
        r_dodge_cnt <= w_dodge_inc;
      end
    end
  end

  assign ene_select = r_ene_select;
  assign ene_valid  = r_ene_valid;
  assign ene_upper  = r_ene_upper;
  assign score      = r_score;
  assign level      = r_level;
  assign game_over  = r_game_over;

endmodule
`default_nettype wire

// File: tb/tb_enemy_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_enemy_scheduler
//  Brief    : Self-checking bench for enemy_scheduler against a game-level
//             reference model (dodge count drives score/level/hold length).
//  Revision : 1.0  initial release
// ============================================================================
module tb_enemy_scheduler;

  localparam int TD = 4;
  localparam int GT = 2;
  localparam int IH = 8;
  localparam int MH = 2;
  localparam int SE = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       hit   = 1'b0;
  logic [2:0] ene_select;
  logic       ene_valid;
  logic       ene_upper;
  logic [7:0] score;
  logic [3:0] level;
  logic       game_over;

  enemy_scheduler #(
    .TICK_DIV(TD), .GAP_TICKS(GT), .INIT_HOLD(IH), .MIN_HOLD(MH),
    .SPEEDUP_EVERY(SE), .LFSR_SEED(8'hA5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hit(hit),
    .ene_select(ene_select), .ene_valid(ene_valid), .ene_upper(ene_upper),
    .score(score), .level(level), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: the game as phases with remaining-tick counts; tick edges
  // are every TD edges after the start edge; score/level/hold follow from the
  // total number of dodges in the current game.
  typedef enum int {M_IDLE, M_GAP, M_SHOW, M_OVER} mode_t;
  mode_t      m_mode;
  logic [7:0] m_lfsr;
  int         m_sel, m_upper, m_dodges, m_rem, m_e, m_g0;

  function automatic int hold_for(input int dodges);
    int h;
    h = IH - dodges / SE;
    return (h < MH) ? MH : h;
  endfunction

  function automatic bit next_is_tick();
    return ((m_e + 1 - m_g0) % TD) == 0;
  endfunction

  task automatic model_edge(input logic s, input logic h, input logic r);
    int  pick;
    bit  tk;
    if (!r) begin
      m_mode = M_IDLE; m_lfsr = 8'hA5; m_sel = 0; m_upper = 0;
      m_dodges = 0; m_rem = 0; m_e = 0; m_g0 = 0;
    end else begin
      m_e++;
      pick   = (m_lfsr[2:0] == 3'd7) ? 3 : int'(m_lfsr[2:0]);
      m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'b1011_1000)};
      tk     = ((m_e - m_g0) % TD) == 0;
      case (m_mode)
        M_IDLE, M_OVER: if (s) begin
          if (m_mode == M_OVER) m_dodges = 0;
          m_mode = M_GAP; m_g0 = m_e; m_rem = GT;
        end
        M_GAP: if (tk) begin
          m_rem--;
          if (m_rem == 0) begin
            m_mode = M_SHOW; m_sel = pick; m_upper = (pick <= 2) ? 1 : 0;
            m_rem = hold_for(m_dodges);
          end
        end
        M_SHOW: if (h) begin
          m_mode = M_OVER;
        end else if (tk) begin
          m_rem--;
          if (m_rem == 0) begin
            m_dodges++; m_mode = M_GAP; m_rem = GT;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    int sc;
    sc = (m_dodges > 255) ? 255 : m_dodges;
    chk("ene_select", 32'(ene_select), 32'(m_sel));
    chk("ene_upper",  32'(ene_upper),  32'(m_upper));
    chk("ene_valid",  32'(ene_valid),  (m_mode == M_SHOW) ? 32'd1 : 32'd0);
    chk("game_over",  32'(game_over),  (m_mode == M_OVER) ? 32'd1 : 32'd0);
    chk("score",      32'(score),      32'(sc));
    chk("level",      32'(level),      32'(IH - hold_for(m_dodges)));
  endtask

  task automatic cyc(input logic s, input logic h, input logic r);
    start = s; hit = h; rst_n = r;
    @(posedge clk);
    model_edge(s, h, r);
    #1;
    check_all();
  endtask

  initial begin
    int first, run, idx, sc, k;

    // Reset held for three edges, then a long idle stretch
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    repeat (50) cyc(1'b0, 1'b0, 1'b1);
    chk("idle_valid", 32'(ene_valid), 32'd0);

    // Start at E0; play without hits, measuring each enemy's on-screen time
    cyc(1'b1, 1'b0, 1'b1);
    first = -1; run = 0; idx = 0;
    for (int i = 1; i < 3000 && m_dodges < 26; i++) begin
      cyc(logic'($urandom_range(0, 7) == 0), 1'b0, 1'b1);
      if (first < 0 && ene_valid === 1'b1) first = i;
      if (ene_valid === 1'b1) run++;
      else if (run > 0) begin
        idx++;
        if (idx == 1)  chk("hold_first", 32'(run), 32'd32);
        if (idx == 5)  chk("hold_fifth", 32'(run), 32'd28);
        if (idx > 24)  chk("hold_min",   32'(run), 32'd8);
        run = 0;
      end
    end
    chk("speedup_budget", 32'(m_dodges >= 26), 32'd1);
    chk("first_spawn",    32'(first), 32'd8);
    chk("level_after_24", 32'(level), 32'd6);

    // Hits during the gap are ignored
    for (int i = 0; i < 200 && m_mode == M_GAP; i++)
      cyc(1'b0, logic'($urandom_range(0, 1)), 1'b1);
    repeat (5) cyc(1'b0, 1'b0, 1'b1);
    sc = int'(score);
    cyc(1'b0, 1'b1, 1'b1);
    chk("collide_over",  32'(game_over), 32'd1);
    chk("collide_valid", 32'(ene_valid), 32'd0);
    repeat (20) cyc(1'b0, logic'($urandom_range(0, 1)), 1'b1);
    chk("score_frozen", 32'(score), 32'(sc));

    // Restart, dodge once, then hit on the final tick of the second enemy
    cyc(1'b1, 1'b0, 1'b1);
    chk("restart_score", 32'(score), 32'd0);
    chk("restart_level", 32'(level), 32'd0);
    for (k = 0; k < 500; k++) begin
      if (m_mode == M_SHOW && m_dodges == 1 && m_rem == 1 && next_is_tick()) break;
      cyc(1'b0, 1'b0, 1'b1);
    end
    chk("final_tick_reached", 32'(k < 500), 32'd1);
    cyc(1'b0, 1'b1, 1'b1);
    chk("simul_score", 32'(score), 32'd1);
    chk("simul_over",  32'(game_over), 32'd1);

    // Restart with start; next spawn comes 8 cycles later
    cyc(1'b1, 1'b1, 1'b1);
    chk("restart2_over",  32'(game_over), 32'd0);
    chk("restart2_score", 32'(score), 32'd0);
    for (k = 1; k < 100; k++) begin
      cyc(1'b0, 1'b0, 1'b1);
      if (ene_valid === 1'b1) break;
    end
    chk("restart_spawn", 32'(k), 32'd8);

    // Mid-game reset while showing with score 3
    for (k = 0; k < 1000; k++) begin
      if (m_mode == M_SHOW && m_dodges == 3 && m_rem < 5) break;
      cyc(1'b0, 1'b0, 1'b1);
    end
    chk("mid_reset_reached", 32'(k < 1000), 32'd1);
    chk("mid_reset_score3",  32'(score), 32'd3);
    cyc(1'b0, 1'b0, 1'b0);
    chk("mid_reset_valid", 32'(ene_valid), 32'd0);
    chk("mid_reset_score", 32'(score), 32'd0);
    repeat (7) cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    repeat (60) cyc(1'b0, 1'b0, 1'b1);

    // Random soak with occasional start, hit and reset
    for (int i = 0; i < 3000; i++)
      cyc(logic'($urandom_range(0, 15) == 0), logic'($urandom_range(0, 39) == 0),
          logic'($urandom_range(0, 499) != 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
